// File: rtl/addr_mode_seq.sv
// Addressing-mode sequencer: MOV/MVI/LDA/LDD, plus LDI when AM_INDIRECT_EN is defined.
// Fetches the immediate and memory operand, then issues a single held writeback.
module addr_mode_seq #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int ACC_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              am_valid,
    output logic              am_ready,
    input  logic [3:0]        am_opcode,
    input  logic [REG_AW-1:0] op1_regaddr,
    input  logic [REG_AW-1:0] op2_regaddr,
    input  logic [DATA_W-1:0] op1_data,
    input  logic [DATA_W-1:0] op2_data,
    output logic              imm_req,
    input  logic              imm_ack,
    input  logic [DATA_W-1:0] imm_data,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_regaddr,
    output logic [DATA_W-1:0] wb_data,
    output logic              am_err
);

    localparam logic [3:0] OP_MOV = 4'b0000;
    localparam logic [3:0] OP_MVI = 4'b0001;
    localparam logic [3:0] OP_LDA = 4'b0010;
    localparam logic [3:0] OP_LDD = 4'b0011;
    localparam logic [3:0] OP_LDI = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_IMM,
        S_MEM,
        S_WB
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          opc_q, opc_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [REG_AW-1:0]   wb_regaddr_q, wb_regaddr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic                am_err_q, am_err_d;

    // The source register address is carried on the bus but never needed here.
    logic unused_op2_regaddr;
    assign unused_op2_regaddr = ^op2_regaddr;

    always_comb begin
        state_d      = state_q;
        opc_d        = opc_q;
        rd_d         = rd_q;
        wb_regaddr_d = wb_regaddr_q;
        wb_data_d    = wb_data_q;
        mem_addr_d   = mem_addr_q;
        am_err_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (am_valid) begin
                    opc_d = am_opcode;
                    rd_d  = op1_regaddr;
                    case (am_opcode)
                        OP_MOV: begin
                            wb_regaddr_d = op1_regaddr;
                            wb_data_d    = op2_data;
                            state_d      = S_WB;
                        end
                        OP_MVI: state_d = S_IMM;
                        OP_LDA: begin
                            wb_regaddr_d = REG_AW'(ACC_ADDR);
                            wb_data_d    = op1_data;
                            state_d      = S_WB;
                        end
                        OP_LDD: state_d = S_IMM;
`ifdef AM_INDIRECT_EN
                        OP_LDI: begin
                            mem_addr_d = op2_data;
                            state_d    = S_MEM;
                        end
`endif
                        default: am_err_d = 1'b1;
                    endcase
                end
            end
            S_IMM: begin
                if (imm_ack) begin
                    if (opc_q == OP_LDD) begin
                        mem_addr_d = imm_data;
                        state_d    = S_MEM;
                    end else begin
                        wb_regaddr_d = rd_q;
                        wb_data_d    = imm_data;
                        state_d      = S_WB;
                    end
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    wb_regaddr_d = rd_q;
                    wb_data_d    = mem_rdata;
                    state_d      = S_WB;
                end
            end
            S_WB: begin
                if (wb_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            opc_q        <= '0;
            rd_q         <= '0;
            wb_regaddr_q <= '0;
            wb_data_q    <= '0;
            mem_addr_q   <= '0;
            am_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            opc_q        <= opc_d;
            rd_q         <= rd_d;
            wb_regaddr_q <= wb_regaddr_d;
            wb_data_q    <= wb_data_d;
            mem_addr_q   <= mem_addr_d;
            am_err_q     <= am_err_d;
        end
    end

    assign am_ready   = (state_q == S_IDLE);
    assign imm_req    = (state_q == S_IMM);
    assign mem_req    = (state_q == S_MEM);
    assign wb_valid   = (state_q == S_WB);
    assign wb_regaddr = wb_regaddr_q;
    assign wb_data    = wb_data_q;
    assign mem_addr   = mem_addr_q;
    assign am_err     = am_err_q;

endmodule
